// File: rtl/segre_pkg.sv
// Shared types and sizing constants for the segre icache refill path.
package segre_pkg;

  localparam int unsigned ICACHE_NUM_LINES = 4;
  localparam int unsigned MEM_BEAT_SIZE    = 32;
  localparam int unsigned ICACHE_BEATS     = 128 / MEM_BEAT_SIZE;

  typedef enum logic [1:0] {
    REFILL_IDLE,
    REFILL_REQ,
    REFILL_FILL,
    REFILL_RESP
  } icache_refill_state_e;

endpackage

// File: rtl/segre_icache_lru.sv
// True-LRU age table for the icache lines; age NUM_LINES-1 marks the victim.
module segre_icache_lru
  import segre_pkg::*;
#(
  parameter int unsigned ICACHE_INDEX_SIZE = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         touch_i,
  input  logic [ICACHE_INDEX_SIZE-1:0] touch_index_i,
  output logic [ICACHE_INDEX_SIZE-1:0] victim_o
);

  localparam int unsigned NUM_LINES = 2 ** ICACHE_INDEX_SIZE;

  logic [ICACHE_INDEX_SIZE-1:0] age_q [NUM_LINES];
  logic [ICACHE_INDEX_SIZE-1:0] age_d [NUM_LINES];

  // Entries younger than the touched one age by one; touched entry becomes MRU.
  always_comb begin
    age_d = age_q;
    if (touch_i) begin
      for (int unsigned j = 0; j < NUM_LINES; j++) begin
        if (age_q[j] < age_q[touch_index_i]) begin
          age_d[j] = age_q[j] + 1'b1;
        end
      end
      age_d[touch_index_i] = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NUM_LINES; i++) begin
        age_q[i] <= ICACHE_INDEX_SIZE'(NUM_LINES - 1 - i);
      end
    end else begin
      age_q <= age_d;
    end
  end

  always_comb begin
    victim_o = '0;
    for (int unsigned j = 0; j < NUM_LINES; j++) begin
      if (age_q[j] == ICACHE_INDEX_SIZE'(NUM_LINES - 1)) begin
        victim_o = ICACHE_INDEX_SIZE'(j);
      end
    end
  end

endmodule

// File: rtl/segre_icache_refill.sv
// Icache miss responder: fetches one line as a beat burst, returns it with a
// one-cycle write strobe and the LRU victim index.
module segre_icache_refill
  import segre_pkg::*;
#(
  parameter int unsigned ADDR_SIZE         = 32,
  parameter int unsigned ICACHE_LANE_SIZE  = 128,
  parameter int unsigned ICACHE_INDEX_SIZE = 2,
  parameter int unsigned ICACHE_BYTE_SIZE  = 4,
  parameter int unsigned MEM_BEAT_SIZE     = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         ic_miss_i,
  input  logic                         ic_access_i,
  input  logic [ADDR_SIZE-1:0]         ic_addr_i,
  output logic                         mmu_data_o,
  output logic [ICACHE_LANE_SIZE-1:0]  mmu_wr_data_o,
  output logic [ICACHE_INDEX_SIZE-1:0] mmu_lru_index_o,
  output logic                         mem_rd_o,
  output logic [ADDR_SIZE-1:0]         mem_addr_o,
  input  logic                         mem_valid_i,
  input  logic [MEM_BEAT_SIZE-1:0]     mem_data_i
);

  localparam int unsigned BEATS  = ICACHE_LANE_SIZE / MEM_BEAT_SIZE;
  localparam int unsigned BEAT_W = $clog2(BEATS);

  icache_refill_state_e          state_q, state_d;
  logic [BEAT_W-1:0]             beat_q, beat_d;
  logic [ICACHE_LANE_SIZE-1:0]   buf_q, buf_d;
  logic [ADDR_SIZE-1:0]          line_addr_q, line_addr_d;
  logic [ICACHE_INDEX_SIZE-1:0]  victim_q, victim_d;

  logic                          touch;
  logic [ICACHE_INDEX_SIZE-1:0]  touch_index;
  logic [ICACHE_INDEX_SIZE-1:0]  lru_victim;
  logic                          stray_beat;
  logic                          unused_addr_bits;

  segre_icache_lru #(
    .ICACHE_INDEX_SIZE(ICACHE_INDEX_SIZE)
  ) u_lru (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .touch_i      (touch),
    .touch_index_i(touch_index),
    .victim_o     (lru_victim)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= REFILL_IDLE;
      beat_q      <= '0;
      buf_q       <= '0;
      line_addr_q <= '0;
      victim_q    <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      buf_q       <= buf_d;
      line_addr_q <= line_addr_d;
      victim_q    <= victim_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    buf_d       = buf_q;
    line_addr_d = line_addr_q;
    victim_d    = victim_q;
    unique case (state_q)
      REFILL_IDLE: begin
        if (ic_access_i && ic_miss_i) begin
          line_addr_d = {ic_addr_i[ADDR_SIZE-1:ICACHE_BYTE_SIZE], {ICACHE_BYTE_SIZE{1'b0}}};
          victim_d    = lru_victim;
          state_d     = REFILL_REQ;
        end
      end
      REFILL_REQ: state_d = REFILL_FILL;
      REFILL_FILL: begin
        if (mem_valid_i) begin
          buf_d[beat_q*MEM_BEAT_SIZE +: MEM_BEAT_SIZE] = mem_data_i;
          if (beat_q == BEAT_W'(BEATS - 1)) begin
            beat_d  = '0;
            state_d = REFILL_RESP;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      REFILL_RESP: state_d = REFILL_IDLE;
      default:     state_d = REFILL_IDLE;
    endcase
  end

  // The victim is touched in RESP; a miss in IDLE suppresses the hit touch.
  always_comb begin
    mmu_data_o       = (state_q == REFILL_RESP);
    mmu_wr_data_o    = buf_q;
    mem_rd_o         = (state_q == REFILL_REQ);
    mem_addr_o       = (state_q == REFILL_REQ) ? line_addr_q : '0;
    mmu_lru_index_o  = (state_q == REFILL_IDLE) ? lru_victim : victim_q;
    touch            = 1'b0;
    touch_index      = ic_addr_i[ICACHE_INDEX_SIZE-1:0];
    if (state_q == REFILL_RESP) begin
      touch       = 1'b1;
      touch_index = victim_q;
    end else if (state_q == REFILL_IDLE && ic_access_i && !ic_miss_i) begin
      touch = 1'b1;
    end
    stray_beat       = mem_valid_i && (state_q != REFILL_FILL);
    unused_addr_bits = ^ic_addr_i;
  end

  // Stray beats are legal but ignored; recorded for debug visibility only.
  cover property (@(posedge clk_i) disable iff (rst_i) stray_beat);

endmodule

// File: tb/tb_segre_icache_refill.sv
// Directed plus randomized bench for segre_icache_refill against a recency-list model.
module tb_segre_icache_refill;

  logic         clk = 1'b0;
  logic         rst;
  logic         ic_miss, ic_access;
  logic [31:0]  ic_addr;
  logic         mmu_data;
  logic [127:0] mmu_wr_data;
  logic [1:0]   mmu_lru_index;
  logic         mem_rd;
  logic [31:0]  mem_addr;
  logic         mem_valid;
  logic [31:0]  mem_data;

  int checks = 0;
  int errors = 0;
  int lru_q[$];
  logic [127:0] last_lane;

  always #5 clk = ~clk;

  segre_icache_refill #(
    .ADDR_SIZE(32), .ICACHE_LANE_SIZE(128), .ICACHE_INDEX_SIZE(2),
    .ICACHE_BYTE_SIZE(4), .MEM_BEAT_SIZE(32)
  ) dut (
    .clk_i(clk), .rst_i(rst), .ic_miss_i(ic_miss), .ic_access_i(ic_access),
    .ic_addr_i(ic_addr), .mmu_data_o(mmu_data), .mmu_wr_data_o(mmu_wr_data),
    .mmu_lru_index_o(mmu_lru_index), .mem_rd_o(mem_rd), .mem_addr_o(mem_addr),
    .mem_valid_i(mem_valid), .mem_data_i(mem_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Recency list: front is MRU, back is the replacement victim.
  task automatic model_reset();
    lru_q = {3, 2, 1, 0};
  endtask

  function automatic int model_victim();
    return lru_q[$];
  endfunction

  task automatic model_touch(input int k);
    for (int i = 0; i < lru_q.size(); i++) begin
      if (lru_q[i] == k) begin
        lru_q.delete(i);
        break;
      end
    end
    lru_q.push_front(k);
  endtask

  // gap < 0: random 0..3 idle cycles before each beat; otherwise fixed gap between beats.
  task automatic do_miss(input logic [31:0] addr, input logic [31:0] bv [4],
                         input int gap, input bit stray);
    int v;
    int g;
    logic [127:0] lane;
    v = model_victim();
    lane = '0;
    ic_access = 1'b1; ic_miss = 1'b1; ic_addr = addr;
    step();
    ic_access = 1'b0; ic_miss = 1'b0;
    if (stray) begin mem_valid = 1'b1; mem_data = $urandom; end
    check("req_rd", mem_rd, 1);
    check("req_addr", mem_addr, {addr[31:4], 4'h0});
    check("req_victim", mmu_lru_index, v);
    step();
    mem_valid = 1'b0;
    check("fill_rd", mem_rd, 0);
    for (int b = 0; b < 4; b++) begin
      g = (gap < 0) ? int'($urandom_range(3, 0)) : ((b > 0) ? gap : 0);
      repeat (g) begin
        mem_valid = 1'b0;
        if (stray) begin
          ic_access = 1'b1; ic_miss = $urandom_range(1, 0) != 0; ic_addr = $urandom;
        end
        step();
        check("gap_strobe", mmu_data, 0);
        check("gap_rd", mem_rd, 0);
      end
      ic_access = 1'b0; ic_miss = 1'b0;
      mem_valid = 1'b1; mem_data = bv[b];
      lane = {bv[b], lane[127:32]};
      step();
      if (b < 3) check("beat_strobe", mmu_data, 0);
    end
    mem_valid = 1'b0;
    check("resp_strobe", mmu_data, 1);
    check("resp_lane", mmu_wr_data, lane);
    check("resp_victim", mmu_lru_index, v);
    check("resp_rd", mem_rd, 0);
    model_touch(v);
    step();
    check("post_strobe", mmu_data, 0);
    check("post_hold", mmu_wr_data, lane);
    check("post_victim", mmu_lru_index, model_victim());
    last_lane = lane;
  endtask

  task automatic do_hit(input int k);
    logic [31:0] a;
    a = $urandom;
    ic_access = 1'b1; ic_miss = 1'b0; ic_addr = {a[31:2], 2'(k)};
    step();
    ic_access = 1'b0;
    model_touch(k);
    check("hit_victim", mmu_lru_index, model_victim());
  endtask

  task automatic idle_stray();
    int v;
    v = model_victim();
    mem_valid = 1'b1; mem_data = $urandom;
    step();
    mem_valid = 1'b0;
    check("stray_rd", mem_rd, 0);
    check("stray_strobe", mmu_data, 0);
    check("stray_hold", mmu_wr_data, last_lane);
    check("stray_victim", mmu_lru_index, v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] bv [4];
    logic [31:0] rv [4];
    rst = 1'b1; ic_miss = 1'b0; ic_access = 1'b0; ic_addr = '0;
    mem_valid = 1'b0; mem_data = '0;
    model_reset();
    last_lane = '0;
    step(); step();
    check("rst_strobe", mmu_data, 0);
    check("rst_rd", mem_rd, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_victim", mmu_lru_index, 0);
    check("rst_lane", mmu_wr_data, 0);
    rst = 1'b0;
    step();

    bv = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    do_miss(32'h0000_1234, bv, 0, 1'b0);
    check("basic_lane", last_lane, 128'h44444444_33333333_22222222_11111111);

    for (int i = 0; i < 3; i++) begin
      foreach (rv[j]) rv[j] = $urandom;
      check("order_victim", mmu_lru_index, i + 1);
      do_miss($urandom, rv, 0, 1'b0);
    end
    do_hit(0);
    check("hit0_next", mmu_lru_index, 1);
    do_hit(1);
    check("hit1_next", mmu_lru_index, 2);

    do_miss(32'h0000_2000, bv, 3, 1'b0);
    check("gapped_lane", last_lane, 128'h44444444_33333333_22222222_11111111);

    idle_stray();
    idle_stray();
    do_miss(32'h0000_3008, bv, 2, 1'b1);

    ic_access = 1'b1; ic_miss = 1'b1; ic_addr = 32'h0000_0080;
    step();
    ic_access = 1'b0; ic_miss = 1'b0;
    step();
    for (int b = 0; b < 2; b++) begin
      mem_valid = 1'b1; mem_data = 32'hDEAD_0000 + b;
      step();
    end
    mem_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    last_lane = '0;
    check("mid_rst_strobe", mmu_data, 0);
    check("mid_rst_rd", mem_rd, 0);
    check("mid_rst_lane", mmu_wr_data, 0);
    check("mid_rst_victim", mmu_lru_index, 0);
    step(); step();
    check("mid_rst_quiet", mmu_data, 0);
    rv = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
    do_miss(32'h0000_0040, rv, -1, 1'b0);
    check("post_rst_lane", last_lane, 128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0);

    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(2, 0))
        0: begin
          foreach (rv[j]) rv[j] = $urandom;
          do_miss($urandom, rv, -1, $urandom_range(1, 0) != 0);
        end
        1: do_hit(int'($urandom_range(3, 0)));
        default: idle_stray();
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
